// File: rtl/alu_issue_ctrl.sv
// Credit-gated command/response feeder for a pipelined ALU; accept->issue 1 cycle, issue->rsp_valid_o ALU_LAT+1 cycles.
// Backpressure: cmd_ready_o drops on a full command FIFO; issue stalls once in-flight plus pending responses fill the response FIFO.

module alu_issue_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] wdat,
   input  logic         pop,
   output logic [W-1:0] rdat,
   output logic [AW:0]  count
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wdat;
   end

   // Storage is not reset, so the head is forced to zero while empty.
   assign rdat = (count != '0) ? mem[rptr] : '0;
endmodule

module alu_issue_ctrl #(
   parameter int WIDTH     = 8,
   parameter int OP_W      = 2,
   parameter int CMD_DEPTH = 4,
   parameter int RSP_DEPTH = 4,
   parameter int ALU_LAT   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [WIDTH-1:0] cmd_a_i,
   input  logic [WIDTH-1:0] cmd_b_i,
   input  logic [OP_W-1:0]  cmd_op_i,
   output logic [WIDTH-1:0] alu_a_o,
   output logic [WIDTH-1:0] alu_b_o,
   output logic [OP_W-1:0]  alu_op_o,
   input  logic [WIDTH-1:0] alu_result_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [WIDTH-1:0] rsp_result_o,
   output logic [OP_W-1:0]  rsp_op_o,
   output logic             busy_o
);
   localparam int CW = $clog2(CMD_DEPTH) + 1;
   localparam int RW = $clog2(RSP_DEPTH) + 1;
   localparam int SW = RW + $clog2(ALU_LAT + 1) + 1;

   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } cmd_t;

   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [WIDTH-1:0] result;
   } rsp_t;

   logic               run_q;
   cmd_t               cmd_wdat;
   cmd_t               cmd_head;
   logic [CW-1:0]      cmd_count;
   logic               cmd_push;
   logic               issue;
   rsp_t               rsp_wdat;
   rsp_t               rsp_head;
   logic [RW-1:0]      rsp_count;
   logic               rsp_pop;
   logic               cap_vld;
   logic [ALU_LAT-1:0] pipe_vld;
   logic [OP_W-1:0]    pipe_op [ALU_LAT];
   logic [SW-1:0]      inflight;

   // Holds off command acceptance until the first clock after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) run_q <= 1'b0;
      else        run_q <= 1'b1;
   end

   assign cmd_ready_o = run_q && (cmd_count != CW'(CMD_DEPTH));
   assign cmd_push    = cmd_valid_i && cmd_ready_o;
   assign cmd_wdat    = '{op: cmd_op_i, a: cmd_a_i, b: cmd_b_i};

   alu_issue_fifo #(
      .W     ($bits(cmd_t)),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_push),
      .wdat  (cmd_wdat),
      .pop   (issue),
      .rdat  (cmd_head),
      .count (cmd_count)
   );

   // Every in-flight op owns a response slot, so capture can never overflow.
   assign inflight = SW'($countones(pipe_vld));
   assign issue    = (cmd_count != '0) && ((inflight + SW'(rsp_count)) < SW'(RSP_DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_vld <= '0;
         for (int i = 0; i < ALU_LAT; i++) pipe_op[i] <= '0;
         alu_a_o  <= '0;
         alu_b_o  <= '0;
         alu_op_o <= '0;
      end else begin
         pipe_vld[0] <= issue;
         pipe_op[0]  <= cmd_head.op;
         for (int i = 1; i < ALU_LAT; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_op[i]  <= pipe_op[i-1];
         end
         if (issue) begin
            alu_a_o  <= cmd_head.a;
            alu_b_o  <= cmd_head.b;
            alu_op_o <= cmd_head.op;
         end
      end
   end

   assign cap_vld  = pipe_vld[ALU_LAT-1];
   assign rsp_wdat = '{op: pipe_op[ALU_LAT-1], result: alu_result_i};

   alu_issue_fifo #(
      .W     ($bits(rsp_t)),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cap_vld),
      .wdat  (rsp_wdat),
      .pop   (rsp_pop),
      .rdat  (rsp_head),
      .count (rsp_count)
   );

   assign rsp_valid_o  = (rsp_count != '0);
   assign rsp_pop      = rsp_valid_o && rsp_ready_i;
   assign rsp_result_o = rsp_head.result;
   assign rsp_op_o     = rsp_head.op;
   assign busy_o       = (cmd_count != '0) || (inflight != '0) || (rsp_count != '0);

   a_no_rsp_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      cap_vld |-> (rsp_count != RW'(RSP_DEPTH)));
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed latency/credit/reset steps plus random traffic against a queue model.
module tb_alu_issue_ctrl;
   logic       clk = 1'b0;
   logic       rst_n;
   always #5 clk = ~clk;

   // ALU_LAT=1 instance
   logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
   logic [7:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, rsp_result;
   logic [1:0] cmd_op, alu_op, rsp_op;

   // ALU_LAT=3 instance
   logic       d3_cmd_valid, d3_cmd_ready, d3_rsp_valid, d3_rsp_ready, d3_busy;
   logic [7:0] d3_cmd_a, d3_cmd_b, d3_alu_a, d3_alu_b, d3_alu_result, d3_rsp_result;
   logic [1:0] d3_cmd_op, d3_alu_op, d3_rsp_op;
   logic [7:0] d3_r1, d3_r2;

   int         nchk = 0;
   int         nfail = 0;
   int         nrsp = 0;
   logic [9:0] exp_q [$];
   logic [7:0] bb_exp [4] = '{8'hFF, 8'hE1, 8'h00, 8'hFF};

   function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
      case (op)
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a & b;
         default: return a | b;
      endcase
   endfunction

   // Bench ALU: the DUT operand registers are the first latency stage.
   assign alu_result = alu_f(alu_a, alu_b, alu_op);
   always @(posedge clk) begin
      d3_r1 <= alu_f(d3_alu_a, d3_alu_b, d3_alu_op);
      d3_r2 <= d3_r1;
   end
   assign d3_alu_result = d3_r2;

   alu_issue_ctrl #(.WIDTH(8), .OP_W(2), .CMD_DEPTH(4), .RSP_DEPTH(4), .ALU_LAT(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_op_i(cmd_op),
      .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_result_i(alu_result),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
      .rsp_op_o(rsp_op), .busy_o(busy));

   alu_issue_ctrl #(.WIDTH(8), .OP_W(2), .CMD_DEPTH(4), .RSP_DEPTH(4), .ALU_LAT(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .cmd_valid_i(d3_cmd_valid), .cmd_ready_o(d3_cmd_ready),
      .cmd_a_i(d3_cmd_a), .cmd_b_i(d3_cmd_b), .cmd_op_i(d3_cmd_op),
      .alu_a_o(d3_alu_a), .alu_b_o(d3_alu_b), .alu_op_o(d3_alu_op), .alu_result_i(d3_alu_result),
      .rsp_valid_o(d3_rsp_valid), .rsp_ready_i(d3_rsp_ready), .rsp_result_o(d3_rsp_result),
      .rsp_op_o(d3_rsp_op), .busy_o(d3_busy));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard bookkeeping for the current cycle, then advance to 1ns after the next edge.
   task automatic cycle();
      logic       hold;
      logic [9:0] held;
      hold = rsp_valid && !rsp_ready;
      held = {rsp_op, rsp_result};
      if (cmd_valid && cmd_ready) exp_q.push_back({cmd_op, alu_f(cmd_a, cmd_b, cmd_op)});
      if (rsp_valid && rsp_ready) begin
         chk("rsp_spurious", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) chk("rsp_order", 32'({rsp_op, rsp_result}), 32'(exp_q.pop_front()));
         nrsp++;
      end
      @(posedge clk);
      #1;
      if (hold) chk("rsp_stable", 32'({rsp_op, rsp_result}), 32'(held));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int base;
      int npush;
      int j;
      logic acc;

      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b1;
      d3_cmd_valid = 1'b0; d3_cmd_a = '0; d3_cmd_b = '0; d3_cmd_op = '0; d3_rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_rsp_result", rsp_result, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_cmd_ready", cmd_ready, 1);

      // Single add: 05+03
      cmd_valid = 1'b1; cmd_a = 8'h05; cmd_b = 8'h03; cmd_op = 2'd0;
      cycle();
      cmd_valid = 1'b0;
      chk("lat_c1_alu_a", alu_a, 0);
      chk("lat_c1_busy", busy, 1);
      cycle();
      chk("lat_c2_alu_a", alu_a, 8'h05);
      chk("lat_c2_alu_b", alu_b, 8'h03);
      chk("lat_c2_rsp_valid", rsp_valid, 0);
      cycle();
      chk("lat_c3_rsp_valid", rsp_valid, 1);
      chk("lat_c3_rsp_result", rsp_result, 8'h08);
      chk("lat_c3_rsp_op", rsp_op, 0);
      cycle();
      chk("lat_c4_rsp_valid", rsp_valid, 0);
      chk("lat_c4_busy", busy, 0);

      // Back-to-back ops 0..3 on F0/0F
      for (int t = 0; t < 8; t++) begin
         cmd_valid = (t < 4); cmd_a = 8'hF0; cmd_b = 8'h0F; cmd_op = 2'(t);
         if (t < 4) chk("bb_cmd_ready", cmd_ready, 1);
         if (t >= 2 && t <= 5) chk("bb_issue_op", alu_op, 32'(t - 2));
         if (t >= 3 && t <= 6) begin
            chk("bb_rsp_valid", rsp_valid, 1);
            chk("bb_rsp_result", rsp_result, bb_exp[t-3]);
            chk("bb_rsp_op", rsp_op, 32'(t - 3));
         end else begin
            chk("bb_rsp_idle", rsp_valid, 0);
         end
         cycle();
      end
      cmd_valid = 1'b0;

      // Response backpressure: 8 commands, credit caps issue at 4
      rsp_ready = 1'b0;
      k = 0;
      for (int n = 0; n < 40 && k < 8; n++) begin
         cmd_valid = 1'b1; cmd_a = 8'(8'h10 + k); cmd_b = 8'(k); cmd_op = 2'(k);
         acc = cmd_ready;
         cycle();
         if (acc) k++;
      end
      cmd_valid = 1'b0;
      chk("bp_all_accepted", k, 8);
      repeat (3) cycle();
      chk("bp_cmd_full", cmd_ready, 0);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_head", rsp_result, 8'h10);
      chk("bp_issue_stalled", alu_a, 8'h13);
      chk("bp_busy", busy, 1);
      base = nrsp;
      rsp_ready = 1'b1;
      chk("full_pop_cycle_x", cmd_ready, 0);
      cycle();
      chk("full_pop_same_cycle", cmd_ready, 0);
      cycle();
      chk("full_ready_rises", cmd_ready, 1);
      for (int n = 0; n < 60 && exp_q.size() != 0; n++) cycle();
      chk("bp_drained", nrsp - base, 8);

      // Random traffic
      base = nrsp;
      npush = 0;
      for (int n = 0; n < 400; n++) begin
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_op = 2'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         if (cmd_valid && cmd_ready) npush++;
         cycle();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int n = 0; n < 60 && busy; n++) cycle();
      chk("rand_all_returned", nrsp - base, npush);
      chk("rand_idle", busy, 0);

      // Reset with work in flight and responses pending
      rsp_ready = 1'b0;
      for (int t = 0; t < 4; t++) begin
         cmd_valid = 1'b1; cmd_a = 8'(8'h40 + t); cmd_b = 8'h01; cmd_op = 2'd1;
         cycle();
      end
      cmd_valid = 1'b0;
      chk("pre_rst_rsp_valid", rsp_valid, 1);
      chk("pre_rst_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_cmd_ready", cmd_ready, 0);
      chk("mid_rst_alu_a", alu_a, 0);
      chk("mid_rst_rsp_result", rsp_result, 0);
      exp_q.delete();
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      for (int t = 0; t < 6; t++) begin
         chk("post_rst_no_rsp", rsp_valid, 0);
         chk("post_rst_busy", busy, 0);
         cycle();
      end
      chk("post_rst_ready", cmd_ready, 1);

      // ALU_LAT=3: 7F+01 valid in cycle 5 only
      for (int t = 0; t < 8; t++) begin
         d3_cmd_valid = (t == 0); d3_cmd_a = 8'h7F; d3_cmd_b = 8'h01; d3_cmd_op = 2'd0;
         if (t == 5) begin
            chk("l3_rsp_valid_c5", d3_rsp_valid, 1);
            chk("l3_rsp_result_c5", d3_rsp_result, 8'h80);
         end else begin
            chk("l3_rsp_idle", d3_rsp_valid, 0);
         end
         cycle();
      end

      // ALU_LAT=3 credit: issue stalls at 4 outstanding
      d3_rsp_ready = 1'b0;
      k = 0;
      for (int n = 0; n < 30 && k < 6; n++) begin
         d3_cmd_valid = 1'b1; d3_cmd_a = 8'(8'h20 + k); d3_cmd_b = 8'h01; d3_cmd_op = 2'd0;
         acc = d3_cmd_ready;
         cycle();
         if (acc) k++;
      end
      d3_cmd_valid = 1'b0;
      chk("l3_accepted", k, 6);
      repeat (12) cycle();
      chk("l3_issue_stalled", d3_alu_a, 8'h23);
      chk("l3_rsp_head", d3_rsp_result, 8'h21);
      chk("l3_cmd_not_full", d3_cmd_ready, 1);
      chk("l3_busy", d3_busy, 1);
      d3_rsp_ready = 1'b1;
      j = 0;
      for (int n = 0; n < 60 && j < 6; n++) begin
         if (d3_rsp_valid) begin
            chk("l3_order", d3_rsp_result, 32'(8'(8'h21 + j)));
            j++;
         end
         cycle();
      end
      chk("l3_drained", j, 6);
      chk("l3_idle", d3_busy, 0);

      $display("%0d/%0d checks passed", nchk - nfail, nchk);
      $finish;
   end
endmodule
